// File: rtl/branch_redirect_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_unit_if
// Brief    : Stall/flush, Decode prediction, Memory resolution and counter bus
// Revision : 1.0
// ============================================================================
interface branch_redirect_unit_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 stallE;
    logic                 stallM;
    logic                 flushE;
    logic                 flushM;
    logic                 branchD;
    logic                 pred_takeD;
    logic [31:0]          pc_plus4D;
    logic [31:0]          branch_targetD;
    logic                 actual_takeM;
    logic                 pred_redirectD;
    logic [31:0]          pred_targetD;
    logic                 mispredM;
    logic [31:0]          recover_pcM;
    logic                 flush_mispred;
    logic [CNT_WIDTH-1:0] branch_cnt;
    logic [CNT_WIDTH-1:0] mispred_cnt;

    modport slave (
        input  stallE, stallM, flushE, flushM, branchD, pred_takeD,
               pc_plus4D, branch_targetD, actual_takeM,
        output pred_redirectD, pred_targetD, mispredM, recover_pcM,
               flush_mispred, branch_cnt, mispred_cnt
    );

    modport master (
        output stallE, stallM, flushE, flushM, branchD, pred_takeD,
               pc_plus4D, branch_targetD, actual_takeM,
        input  pred_redirectD, pred_targetD, mispredM, recover_pcM,
               flush_mispred, branch_cnt, mispred_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_unit
// Brief    : Decode-stage predicted redirect, Memory-stage mispredict recovery
//            and retired/mispredicted branch performance counters
// Revision : 1.0
// ============================================================================
module branch_redirect_unit #(
    parameter int CNT_WIDTH = 32
) (
    input  wire                    clk,
    input  wire                    rst,
    branch_redirect_unit_if.slave  bus
);

    typedef struct packed {
        logic        validBr;
        logic        pred;
        logic [31:0] pcPlus4;
        logic [31:0] target;
    } stageRec_t;

    localparam logic [CNT_WIDTH-1:0] c_cntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    stageRec_t            r_recE;
    stageRec_t            r_recM;
    logic [CNT_WIDTH-1:0] r_branchCnt;
    logic [CNT_WIDTH-1:0] r_mispredCnt;
    logic                 w_mispredM;
    logic                 w_retireM;

    // A stalled M branch neither recovers nor retires until it can leave M.
    assign w_retireM  = r_recM.validBr & ~bus.stallM;
    assign w_mispredM = w_retireM & (r_recM.pred != bus.actual_takeM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_recE       <= '0;
            r_recM       <= '0;
            r_branchCnt  <= '0;
            r_mispredCnt <= '0;
        end else begin
            // Clears win over stalls so a recovery always squashes younger work.
            if (bus.flushE || w_mispredM) begin
                r_recE <= '0;
            end else if (!bus.stallE) begin
                r_recE <= '{bus.branchD, bus.pred_takeD, bus.pc_plus4D, bus.branch_targetD};
            end

            if (bus.flushM || w_mispredM) begin
                r_recM <= '0;
            end else if (!bus.stallM) begin
                r_recM <= r_recE;
            end

            if (w_retireM) begin
                r_branchCnt <= r_branchCnt + c_cntOne;
                if (w_mispredM) begin
                    r_mispredCnt <= r_mispredCnt + c_cntOne;
                end
            end
        end
    end

    assign bus.pred_redirectD = bus.pred_takeD & ~w_mispredM;
    assign bus.pred_targetD   = bus.branch_targetD;
    assign bus.mispredM       = w_mispredM;
    assign bus.flush_mispred  = w_mispredM;
    assign bus.recover_pcM    = bus.actual_takeM ? r_recM.target : r_recM.pcPlus4;
    assign bus.branch_cnt     = r_branchCnt;
    assign bus.mispred_cnt    = r_mispredCnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_redirect_unit
// Brief    : Self-checking bench for branch_redirect_unit
// Revision : 1.0
// ============================================================================
module tb_branch_redirect_unit;

    localparam int CNT_WIDTH = 32;

    logic clk;
    logic rst;

    branch_redirect_unit_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

    branch_redirect_unit #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pred;
        logic        act;
        logic [31:0] target;
        logic [31:0] pc4;
        logic        expMis;
        logic [31:0] expRec;
    } vec_t;

    typedef struct {
        logic        mis;
        logic [31:0] rec;
    } expM_t;

    vec_t  vecs[5];
    expM_t sb[$];
    expM_t e;
    int    checks;
    int    failures;
    int    expBr;
    int    expMis;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkCounters(input string tag);
        chk({tag, "_branch_cnt"}, bus.branch_cnt, expBr);
        chk({tag, "_mispred_cnt"}, bus.mispred_cnt, expMis);
    endtask

    // Places one branch in D for a single cycle, then returns D to idle.
    task automatic issueBranch(input logic pred, input logic [31:0] pc4, input logic [31:0] tgt);
        bus.branchD        = 1'b1;
        bus.pred_takeD     = pred;
        bus.pc_plus4D      = pc4;
        bus.branch_targetD = tgt;
        tick();
        bus.branchD        = 1'b0;
        bus.pred_takeD     = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        expBr    = 0;
        expMis   = 0;

        vecs[0] = '{1'b1, 1'b1, 32'h0000_0100, 32'h0000_0044, 1'b0, 32'h0000_0100};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0000_0044, 1'b1, 32'h0000_0100};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0044, 1'b1, 32'h0000_0044};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_2000, 32'h0000_1004, 1'b0, 32'h0000_1004};
        vecs[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h8000_0000, 1'b0, 32'hFFFF_FFFC};

        rst                = 1'b0;
        bus.stallE         = 1'b0;
        bus.stallM         = 1'b0;
        bus.flushE         = 1'b0;
        bus.flushM         = 1'b0;
        bus.branchD        = 1'b0;
        bus.pred_takeD     = 1'b0;
        bus.pc_plus4D      = '0;
        bus.branch_targetD = '0;
        bus.actual_takeM   = 1'b0;

        #2 rst = 1'b1;
        #1;
        chkCounters("reset");
        chk("reset_mispredM", bus.mispredM, 1'b0);
        chk("reset_flush", bus.flush_mispred, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single isolated branches: D at edge k, M during cycle k+2.
        for (int i = 0; i < 5; i++) begin
            bus.branchD        = 1'b1;
            bus.pred_takeD     = vecs[i].pred;
            bus.pc_plus4D      = vecs[i].pc4;
            bus.branch_targetD = vecs[i].target;
            sb.push_back('{vecs[i].expMis, vecs[i].expRec});
            #1;
            chk("vec_redirectD", bus.pred_redirectD, vecs[i].pred);
            chk("vec_targetD", bus.pred_targetD, vecs[i].target);
            tick();
            bus.branchD    = 1'b0;
            bus.pred_takeD = 1'b0;
            tick();
            bus.actual_takeM = vecs[i].act;
            #1;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL vec_scoreboard: got empty queue expected one entry");
            end else begin
                e = sb.pop_front();
                chk("vec_mispredM", bus.mispredM, e.mis);
                chk("vec_flush", bus.flush_mispred, e.mis);
                chk("vec_recover_pc", bus.recover_pcM, e.rec);
                expBr++;
                if (e.mis) expMis++;
            end
            tick();
            bus.actual_takeM = ~vecs[i].act;
            #1;
            chk("vec_after_mispredM", bus.mispredM, 1'b0);
            chkCounters("vec");
            tick();
        end

        // Counters now 5/2; pulse reset between edges while a recovery is pending.
        chkCounters("pre_reset");
        issueBranch(1'b0, 32'h0000_0044, 32'h0000_0100);
        tick();
        bus.actual_takeM = 1'b1;
        #1;
        chk("prereset_mispredM", bus.mispredM, 1'b1);
        #1 rst = 1'b1;
        #1;
        expBr  = 0;
        expMis = 0;
        chkCounters("async_reset");
        chk("async_reset_mispredM", bus.mispredM, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("post_reset_mispredM", bus.mispredM, 1'b0);
        tick();
        chkCounters("post_reset");
        bus.actual_takeM = 1'b0;
        tick();

        // Mispredict in M while D predicts taken and a younger branch sits in E.
        issueBranch(1'b0, 32'h0000_0044, 32'h0000_0100);
        issueBranch(1'b1, 32'h0000_0048, 32'h0000_0200);
        bus.branchD        = 1'b1;
        bus.pred_takeD     = 1'b1;
        bus.pc_plus4D      = 32'h0000_004C;
        bus.branch_targetD = 32'h0000_0300;
        bus.actual_takeM   = 1'b1;
        #1;
        chk("simul_mispredM", bus.mispredM, 1'b1);
        chk("simul_redirectD", bus.pred_redirectD, 1'b0);
        chk("simul_recover_pc", bus.recover_pcM, 32'h0000_0100);
        tick();
        bus.branchD      = 1'b0;
        bus.pred_takeD   = 1'b0;
        bus.actual_takeM = 1'b0;
        expBr++;
        expMis++;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("squashed_mispredM", bus.mispredM, 1'b0);
            tick();
        end
        chkCounters("squashed");

        // Mispredicted branch held in M by a 3-cycle stall.
        issueBranch(1'b0, 32'h0000_0044, 32'h0000_0100);
        tick();
        bus.stallM       = 1'b1;
        bus.actual_takeM = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_mispredM", bus.mispredM, 1'b0);
            chkCounters("stall");
            tick();
        end
        bus.stallM = 1'b0;
        #1;
        chk("unstall_mispredM", bus.mispredM, 1'b1);
        chk("unstall_recover_pc", bus.recover_pcM, 32'h0000_0100);
        tick();
        expBr++;
        expMis++;
        #1;
        chk("unstall_after_mispredM", bus.mispredM, 1'b0);
        chkCounters("unstall");
        bus.actual_takeM = 1'b0;
        tick();
        tick();
        chkCounters("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
